id_stage_hz: RTL and testbench
==============================

// Module: id_stage_hz
// PURPOSE
//  Parametrised decode stage with an integrated register file, load-use hazard detection and an ID/EX pipeline register.
//  Sits between the IF/ID register and EX.
//  Decodes the 4-bit opcode into an 11-bit control vector and resolves jumps in ID.
//  Inserts bubbles on load-use hazards and latches a sticky halt when a HALT instruction reaches EX.
// PARAMETERS
//  DATA_WIDTH  16  register/data width
//  ADDR_WIDTH  8   PC width
//  IMM8_WIDTH  8   immediate / jump target width (must be <= ADDR_WIDTH)
//  REG_WIDTH   4   register index width; the file holds 2**REG_WIDTH regs
//  CV_WIDTH    11  control vector width (fixed at 11; any other value is a config error)
//  ZERO_REG    1   1: R0 always reads 0 and writes to R0 are dropped
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  valid_d_i    in   1           instruction in ID is valid
//  instr_d_i    in   16          [15:12] op, [11:8] rs, [7:4] rt, [3:0] rd, [7:0] imm8
//  pc_d_i       in   ADDR_WIDTH  PC of the ID instruction
//  stall_i      in   1           downstream stall: hold ID/EX
//  flush_i      in   1           kill ID/EX (branch taken in EX)
//  wb_en_i      in   1           register-file write enable (WB)
//  wb_addr_i    in   REG_WIDTH   write index
//  wb_data_i    in   DATA_WIDTH  write data
//  stall_fd_o   out  1           freeze PC and IF/ID
//  jump_o       out  1           jump taken this cycle (combinational)
//  jump_addr_o  out  ADDR_WIDTH  zero-extended imm8
//  valid_e_o, pc_e_o, cv_e_o[CV_WIDTH], rs_data_e_o, rt_data_e_o, imm8_e_o, rs_e_o, rt_e_o, rd_e_o: out, ID/EX register
//  halted_o     out  1           sticky halt
// BEHAVIOUR
//  - Control vector bits [10:0]: RegWrite, ALUop, Branch, MemRead, RegDst, MemWrite, Jump, MemToReg, Mov, Floating, Stop.
//  - Decode table (op -> cv):
//    - 1-4 (ADD/SUB/AND/OR) 0x640; 5 LW 0x488; 6 SW 0x020; 7 BEQ 0x300; 8 JMP 0x010; 9 MOVI 0x404;
//    - A/B (FADD/FMUL) 0x642; F HALT 0x001; 0, C-E -> 0x000 (NOP).
//  - Source usage:
//    - rs is used by ops 1-7 and A-B.
//    - rt is used by ops 1-4, 6, 7 and A-B.
//  - Register file:
//    - Combinational reads; write on posedge when wb_en_i is high.
//    - Same-cycle write/read of the same index returns wb_data_i (write-through bypass).
//    - Register contents are not reset.
//  - Load-use hazard:
//    - dst_e = cv_e[RegDst] ? rd_e : rt_e.
//    - hz = valid_d_i & valid_e_o & cv_e[MemRead] & ((use_rs & rs_d==dst_e) | (use_rt & rt_d==dst_e)).
//  - stall_fd_o = hz | stall_i | halted_o.
//  - jump_o = valid_d_i & op==8 & ~stall_fd_o & ~flush_i; jump_addr_o = imm8.
//  - ID/EX update priority on posedge, highest first:
//    1. rst: all ID/EX outputs 0, halted_o = 0.
//    2. flush_i: valid_e_o = 0, cv_e_o = 0, pc_e_o = 0; data fields don't-care.
//    3. stall_i: hold all fields.
//    4. hz | halted_o: bubble (same as flush).
//    5. else: load from ID; valid_e_o = valid_d_i; cv_e_o = valid_d_i ? cv : 0.
//  - Latency: ID to EX is 1 cycle.
//  - A bubble lasts exactly 1 cycle per load: after the bubble, MemRead is 0 in EX, so hz drops.
//  - halted_o:
//    - Set on the cycle after valid_e_o & cv_e_o[Stop], unless flush_i is high that cycle.
//    - Once set, only rst clears it; thereafter every cycle is a bubble.
//  - Reset mid-operation: all in-flight state is discarded next edge; register-file contents are kept.
// TESTING
//  1. Write R3=0x1234 via WB, then ADD rs=3 rt=3 in the same cycle -> rs_data_e_o = rt_data_e_o = 0x1234, cv_e_o = 0x640 next cycle.
//  2. LW rt=2, then ADD rs=2 -> stall_fd_o=1 for 1 cycle, one bubble (valid_e_o=0, cv 0), then ADD enters EX.
//  3. LW rt=2, then MOVI rt=2 (no source) -> no stall; also SW using rs=2 after LW -> stall.
//  4. JMP imm8=0x5A -> jump_o=1, jump_addr_o=0x5A; with stall_i=1 or flush_i=1 -> jump_o=0.
//  5. stall_i and flush_i both high -> ID/EX cleared; stall_i alone for 3 cycles -> outputs held.
//  6. HALT reaches EX -> halted_o=1 next cycle, stall_fd_o stays 1; rst -> all outputs 0, R0 reads 0 with ZERO_REG=1.

Source files
------------

// File: rtl/id_stage_hz.sv
// id_stage_hz -- decode stage between the IF/ID register and EX.
//   Decodes a 4-bit opcode into an 11-bit control vector, reads a 2**REG_WIDTH
//   entry register file (combinational reads, write-through from WB), detects
//   load-use hazards, resolves jumps in ID and holds the ID/EX pipeline register.
//   A HALT reaching EX latches a sticky halt that turns every later cycle into a bubble.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_d_i, instr_d_i, pc_d_i   instruction in ID ([15:12] op, [11:8] rs, [7:4] rt, [3:0] rd, [7:0] imm8)
//   stall_i, flush_i            downstream hold / kill of ID/EX
//   wb_en_i, wb_addr_i, wb_data_i  register-file write port
//   stall_fd_o                  freeze PC and IF/ID
//   jump_o, jump_addr_o         jump resolved in ID, zero-extended imm8 target
//   valid_e_o .. rd_e_o         ID/EX register contents
//   halted_o                    sticky halt
module id_stage_hz #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM8_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int CV_WIDTH   = 11,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d_i,
  input  logic [15:0]           instr_d_i,
  input  logic [ADDR_WIDTH-1:0] pc_d_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  wb_en_i,
  input  logic [REG_WIDTH-1:0]  wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  stall_fd_o,
  output logic                  jump_o,
  output logic [ADDR_WIDTH-1:0] jump_addr_o,
  output logic                  valid_e_o,
  output logic [ADDR_WIDTH-1:0] pc_e_o,
  output logic [CV_WIDTH-1:0]   cv_e_o,
  output logic [DATA_WIDTH-1:0] rs_data_e_o,
  output logic [DATA_WIDTH-1:0] rt_data_e_o,
  output logic [IMM8_WIDTH-1:0] imm8_e_o,
  output logic [REG_WIDTH-1:0]  rs_e_o,
  output logic [REG_WIDTH-1:0]  rt_e_o,
  output logic [REG_WIDTH-1:0]  rd_e_o,
  output logic                  halted_o
);

  if (CV_WIDTH != 11) begin : g_bad_cv_width
    $error("id_stage_hz: CV_WIDTH must be 11");
  end
  if (IMM8_WIDTH > ADDR_WIDTH) begin : g_bad_imm_width
    $error("id_stage_hz: IMM8_WIDTH must not exceed ADDR_WIDTH");
  end

  localparam int NREGS      = 2**REG_WIDTH;
  localparam int CV_REGDST  = 6;
  localparam int CV_MEMREAD = 7;
  localparam int CV_STOP    = 0;

  function automatic logic [10:0] decode_cv(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: decode_cv = 11'h640;
      4'h5:                   decode_cv = 11'h488;
      4'h6:                   decode_cv = 11'h020;
      4'h7:                   decode_cv = 11'h300;
      4'h8:                   decode_cv = 11'h010;
      4'h9:                   decode_cv = 11'h404;
      4'hA, 4'hB:             decode_cv = 11'h642;
      4'hF:                   decode_cv = 11'h001;
      default:                decode_cv = 11'h000;
    endcase
  endfunction

  // ---- ID: field extraction and decode ----
  logic [3:0]            op_d;
  logic [REG_WIDTH-1:0]  rs_d, rt_d, rd_d;
  logic [IMM8_WIDTH-1:0] imm8_d;
  logic [CV_WIDTH-1:0]   cv_d;
  logic                  use_rs, use_rt;

  assign op_d   = instr_d_i[15:12];
  assign rs_d   = REG_WIDTH'(instr_d_i[11:8]);
  assign rt_d   = REG_WIDTH'(instr_d_i[7:4]);
  assign rd_d   = REG_WIDTH'(instr_d_i[3:0]);
  assign imm8_d = IMM8_WIDTH'(instr_d_i[7:0]);
  assign cv_d   = CV_WIDTH'(decode_cv(op_d));
  assign use_rs = op_d inside {[4'h1:4'h7], 4'hA, 4'hB};
  assign use_rt = op_d inside {[4'h1:4'h4], 4'h6, 4'h7, 4'hA, 4'hB};

  // Register file. rf_d already carries this cycle's WB write, so reading
  // from it gives the write-through bypass for free.
  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic [DATA_WIDTH-1:0] rf_d [NREGS];
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rs_val, rt_val;

  assign wr_ok = wb_en_i & ~((ZERO_REG != 0) && (wb_addr_i == '0));

  always_comb begin
    rf_d = rf_q;
    if (wr_ok) rf_d[wb_addr_i] = wb_data_i;
  end

  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  assign rs_val = ((ZERO_REG != 0) && (rs_d == '0)) ? '0 : rf_d[rs_d];
  assign rt_val = ((ZERO_REG != 0) && (rt_d == '0)) ? '0 : rf_d[rt_d];

  // ID/EX register state
  logic                  valid_e_q, valid_e_d;
  logic [ADDR_WIDTH-1:0] pc_e_q, pc_e_d;
  logic [CV_WIDTH-1:0]   cv_e_q, cv_e_d;
  logic [DATA_WIDTH-1:0] rs_data_e_q, rs_data_e_d, rt_data_e_q, rt_data_e_d;
  logic [IMM8_WIDTH-1:0] imm8_e_q, imm8_e_d;
  logic [REG_WIDTH-1:0]  rs_e_q, rs_e_d, rt_e_q, rt_e_d, rd_e_q, rd_e_d;
  logic                  halted_q, halted_d;

  // Load-use hazard: the load in EX writes rt unless RegDst selects rd.
  logic [REG_WIDTH-1:0] dst_e;
  logic                 hz;

  assign dst_e = cv_e_q[CV_REGDST] ? rd_e_q : rt_e_q;
  assign hz    = valid_d_i & valid_e_q & cv_e_q[CV_MEMREAD] &
                 ((use_rs & (rs_d == dst_e)) | (use_rt & (rt_d == dst_e)));

  assign stall_fd_o  = hz | stall_i | halted_q;
  assign jump_o      = valid_d_i & (op_d == 4'h8) & ~stall_fd_o & ~flush_i;
  assign jump_addr_o = ADDR_WIDTH'(imm8_d);

  always_comb begin
    valid_e_d   = valid_e_q;
    pc_e_d      = pc_e_q;
    cv_e_d      = cv_e_q;
    rs_data_e_d = rs_data_e_q;
    rt_data_e_d = rt_data_e_q;
    imm8_e_d    = imm8_e_q;
    rs_e_d      = rs_e_q;
    rt_e_d      = rt_e_q;
    rd_e_d      = rd_e_q;
    // A flushed HALT never counts as having reached EX.
    halted_d    = halted_q | (valid_e_q & cv_e_q[CV_STOP] & ~flush_i);
    if (flush_i) begin
      valid_e_d = 1'b0;
      cv_e_d    = '0;
      pc_e_d    = '0;
    end else if (!stall_i) begin
      if (hz || halted_q) begin
        valid_e_d = 1'b0;
        cv_e_d    = '0;
        pc_e_d    = '0;
      end else begin
        valid_e_d   = valid_d_i;
        pc_e_d      = pc_d_i;
        cv_e_d      = valid_d_i ? cv_d : '0;
        rs_data_e_d = rs_val;
        rt_data_e_d = rt_val;
        imm8_e_d    = imm8_d;
        rs_e_d      = rs_d;
        rt_e_d      = rt_d;
        rd_e_d      = rd_d;
      end
    end
  end

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q   <= 1'b0;
      pc_e_q      <= '0;
      cv_e_q      <= '0;
      rs_data_e_q <= '0;
      rt_data_e_q <= '0;
      imm8_e_q    <= '0;
      rs_e_q      <= '0;
      rt_e_q      <= '0;
      rd_e_q      <= '0;
      halted_q    <= 1'b0;
    end else begin
      valid_e_q   <= valid_e_d;
      pc_e_q      <= pc_e_d;
      cv_e_q      <= cv_e_d;
      rs_data_e_q <= rs_data_e_d;
      rt_data_e_q <= rt_data_e_d;
      imm8_e_q    <= imm8_e_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      rd_e_q      <= rd_e_d;
      halted_q    <= halted_d;
    end
  end

  assign valid_e_o   = valid_e_q;
  assign pc_e_o      = pc_e_q;
  assign cv_e_o      = cv_e_q;
  assign rs_data_e_o = rs_data_e_q;
  assign rt_data_e_o = rt_data_e_q;
  assign imm8_e_o    = imm8_e_q;
  assign rs_e_o      = rs_e_q;
  assign rt_e_o      = rt_e_q;
  assign rd_e_o      = rd_e_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz -- directed scenarios plus randomized traffic for id_stage_hz,
// checked against a cycle-level reference model of the decode stage.
module tb_id_stage_hz;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d_i;
  logic [15:0] instr_d_i;
  logic [7:0]  pc_d_i;
  logic        stall_i, flush_i, wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [15:0] wb_data_i;
  logic        stall_fd_o, jump_o, valid_e_o, halted_o;
  logic [7:0]  jump_addr_o, pc_e_o, imm8_e_o;
  logic [10:0] cv_e_o;
  logic [15:0] rs_data_e_o, rt_data_e_o;
  logic [3:0]  rs_e_o, rt_e_o, rd_e_o;

  id_stage_hz dut (
    .clk(clk), .rst(rst), .valid_d_i(valid_d_i), .instr_d_i(instr_d_i), .pc_d_i(pc_d_i),
    .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .stall_fd_o(stall_fd_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
    .valid_e_o(valid_e_o), .pc_e_o(pc_e_o), .cv_e_o(cv_e_o), .rs_data_e_o(rs_data_e_o),
    .rt_data_e_o(rt_data_e_o), .imm8_e_o(imm8_e_o), .rs_e_o(rs_e_o), .rt_e_o(rt_e_o),
    .rd_e_o(rd_e_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural registers and what EX should hold.
  logic [15:0] m_regs [16];
  logic        m_valid_e = 1'b0, m_halted = 1'b0, m_data_ok = 1'b0;
  logic [7:0]  m_pc_e = '0, m_imm = '0;
  logic [10:0] m_cv_e = '0;
  logic [15:0] m_rsd = '0, m_rtd = '0;
  logic [3:0]  m_rs = '0, m_rt = '0, m_rd = '0;

  function automatic logic [10:0] cv_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: return 11'h640;
      4'h5: return 11'h488;
      4'h6: return 11'h020;
      4'h7: return 11'h300;
      4'h8: return 11'h010;
      4'h9: return 11'h404;
      4'hA, 4'hB: return 11'h642;
      4'hF: return 11'h001;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic reads_rs(input logic [3:0] op);
    return (op >= 4'h1 && op <= 4'h7) || op == 4'hA || op == 4'hB;
  endfunction

  function automatic logic reads_rt(input logic [3:0] op);
    return (op >= 4'h1 && op <= 4'h4) || op == 4'h6 || op == 4'h7 || op == 4'hA || op == 4'hB;
  endfunction

  // Value an instruction in ID sees for a register, including the WB write this cycle.
  function automatic logic [15:0] m_read(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0000;
    if (wb_en_i && wb_addr_i == idx) return wb_data_i;
    return m_regs[idx];
  endfunction

  function automatic logic m_hz();
    logic [3:0] dst;
    dst = m_cv_e[6] ? m_rd : m_rt;
    return valid_d_i && m_valid_e && m_cv_e[7] &&
           ((reads_rs(instr_d_i[15:12]) && instr_d_i[11:8] == dst) ||
            (reads_rt(instr_d_i[15:12]) && instr_d_i[7:4] == dst));
  endfunction

  task automatic idle();
    rst = 1'b0; valid_d_i = 1'b0; instr_d_i = '0; pc_d_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
  endtask

  // Advance the model by one clock from the current inputs, then step the DUT.
  task automatic tick();
    logic n_valid, n_halted, n_ok;
    logic [7:0] n_pc, n_imm;
    logic [10:0] n_cv;
    logic [15:0] n_rsd, n_rtd;
    logic [3:0] n_rs, n_rt, n_rd;
    logic hz;
    hz = m_hz();
    n_valid = m_valid_e; n_pc = m_pc_e; n_cv = m_cv_e; n_rsd = m_rsd; n_rtd = m_rtd;
    n_imm = m_imm; n_rs = m_rs; n_rt = m_rt; n_rd = m_rd; n_ok = m_data_ok;
    n_halted = m_halted || (m_valid_e && m_cv_e[0] && !flush_i);
    if (rst) begin
      n_valid = 0; n_pc = 0; n_cv = 0; n_rsd = 0; n_rtd = 0; n_imm = 0;
      n_rs = 0; n_rt = 0; n_rd = 0; n_ok = 1; n_halted = 0;
    end else if (flush_i || (!stall_i && (hz || m_halted))) begin
      n_valid = 0; n_cv = 0; n_pc = 0; n_ok = 0;
    end else if (!stall_i) begin
      n_valid = valid_d_i; n_pc = pc_d_i; n_cv = valid_d_i ? cv_of(instr_d_i[15:12]) : 11'h0;
      n_rsd = m_read(instr_d_i[11:8]); n_rtd = m_read(instr_d_i[7:4]);
      n_imm = instr_d_i[7:0]; n_rs = instr_d_i[11:8]; n_rt = instr_d_i[7:4]; n_rd = instr_d_i[3:0];
      n_ok = 1;
    end
    if (wb_en_i && wb_addr_i != 4'd0) m_regs[wb_addr_i] = wb_data_i;
    @(posedge clk);
    #1;
    m_valid_e = n_valid; m_pc_e = n_pc; m_cv_e = n_cv; m_rsd = n_rsd; m_rtd = n_rtd;
    m_imm = n_imm; m_rs = n_rs; m_rt = n_rt; m_rd = n_rd; m_data_ok = n_ok; m_halted = n_halted;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    vectors++; if (valid_e_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid_e got %h want 0", valid_e_o); end
    vectors++; if (cv_e_o !== 11'h000) begin miscompares++; $display("FAIL reset_cv_e got %h want 000", cv_e_o); end
    vectors++; if (pc_e_o !== 8'h00) begin miscompares++; $display("FAIL reset_pc_e got %h want 00", pc_e_o); end
    vectors++; if ({rs_data_e_o, rt_data_e_o, imm8_e_o, rs_e_o, rt_e_o, rd_e_o} !== 52'h0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h want all 0", rs_data_e_o, rt_data_e_o, imm8_e_o); end
    vectors++; if (halted_o !== 1'b0 || stall_fd_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_halt_stall got %b%b want 00", halted_o, stall_fd_o); end
    rst = 1'b0;
    m_regs[0] = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      wb_en_i = 1'b1; wb_addr_i = 4'(i); wb_data_i = 16'hA000 | 16'(i);
      tick();
    end
    idle();
  endtask

  task automatic test_rf_bypass();
    wb_en_i = 1'b1; wb_addr_i = 4'd3; wb_data_i = 16'h1234;
    valid_d_i = 1'b1; instr_d_i = 16'h1330; pc_d_i = 8'h10;
    tick();
    idle();
    vectors++; if (rs_data_e_o !== 16'h1234 || rt_data_e_o !== 16'h1234) begin
      miscompares++; $display("FAIL bypass_data got %h %h want 1234 1234", rs_data_e_o, rt_data_e_o); end
    vectors++; if (cv_e_o !== 11'h640 || valid_e_o !== 1'b1 || pc_e_o !== 8'h10) begin
      miscompares++; $display("FAIL bypass_ctrl got cv=%h v=%b pc=%h want 640 1 10", cv_e_o, valid_e_o, pc_e_o); end
  endtask

  task automatic test_load_use();
    valid_d_i = 1'b1; instr_d_i = 16'h5120; pc_d_i = 8'h11;
    tick();
    vectors++; if (cv_e_o !== 11'h488) begin miscompares++; $display("FAIL lw_cv got %h want 488", cv_e_o); end
    instr_d_i = 16'h1245; pc_d_i = 8'h12;
    #1;
    vectors++; if (stall_fd_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", stall_fd_o); end
    tick();
    vectors++; if (valid_e_o !== 1'b0 || cv_e_o !== 11'h000) begin
      miscompares++; $display("FAIL lu_bubble got v=%b cv=%h want 0 000", valid_e_o, cv_e_o); end
    #1;
    vectors++; if (stall_fd_o !== 1'b0) begin miscompares++; $display("FAIL lu_stall_drop got %b want 0", stall_fd_o); end
    tick();
    vectors++; if (valid_e_o !== 1'b1 || cv_e_o !== 11'h640 || pc_e_o !== 8'h12 || rs_data_e_o !== 16'hA002) begin
      miscompares++; $display("FAIL lu_add got v=%b cv=%h pc=%h rs=%h want 1 640 12 a002", valid_e_o, cv_e_o, pc_e_o, rs_data_e_o); end
    instr_d_i = 16'h5120; pc_d_i = 8'h13;
    tick();
    instr_d_i = 16'h9020; pc_d_i = 8'h14;
    #1;
    vectors++; if (stall_fd_o !== 1'b0) begin miscompares++; $display("FAIL movi_nostall got %b want 0", stall_fd_o); end
    tick();
    vectors++; if (cv_e_o !== 11'h404 || valid_e_o !== 1'b1) begin
      miscompares++; $display("FAIL movi_cv got %h v=%b want 404 1", cv_e_o, valid_e_o); end
    instr_d_i = 16'h5120; pc_d_i = 8'h15;
    tick();
    instr_d_i = 16'h6230; pc_d_i = 8'h16;
    #1;
    vectors++; if (stall_fd_o !== 1'b1) begin miscompares++; $display("FAIL sw_stall got %b want 1", stall_fd_o); end
    tick();
    vectors++; if (valid_e_o !== 1'b0) begin miscompares++; $display("FAIL sw_bubble got %b want 0", valid_e_o); end
    tick();
    vectors++; if (cv_e_o !== 11'h020 || pc_e_o !== 8'h16) begin
      miscompares++; $display("FAIL sw_cv got %h pc=%h want 020 16", cv_e_o, pc_e_o); end
    idle();
  endtask

  task automatic test_jump();
    valid_d_i = 1'b1; instr_d_i = 16'h805A; pc_d_i = 8'h17;
    #1;
    vectors++; if (jump_o !== 1'b1 || jump_addr_o !== 8'h5A) begin
      miscompares++; $display("FAIL jmp got %b addr=%h want 1 5a", jump_o, jump_addr_o); end
    stall_i = 1'b1; #1;
    vectors++; if (jump_o !== 1'b0) begin miscompares++; $display("FAIL jmp_stall got %b want 0", jump_o); end
    stall_i = 1'b0; flush_i = 1'b1; #1;
    vectors++; if (jump_o !== 1'b0) begin miscompares++; $display("FAIL jmp_flush got %b want 0", jump_o); end
    flush_i = 1'b0;
    tick();
    vectors++; if (cv_e_o !== 11'h010) begin miscompares++; $display("FAIL jmp_cv got %h want 010", cv_e_o); end
    idle();
  endtask

  task automatic test_stall_flush();
    valid_d_i = 1'b1; instr_d_i = 16'h1345; pc_d_i = 8'h21;
    tick();
    vectors++; if (rs_data_e_o !== 16'h1234 || rt_data_e_o !== 16'hA004) begin
      miscompares++; $display("FAIL sf_load got %h %h want 1234 a004", rs_data_e_o, rt_data_e_o); end
    stall_i = 1'b1; instr_d_i = 16'h2678; pc_d_i = 8'h22;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (valid_e_o !== 1'b1 || cv_e_o !== 11'h640 || pc_e_o !== 8'h21 || rs_data_e_o !== 16'h1234) begin
        miscompares++; $display("FAIL stall_hold[%0d] got v=%b cv=%h pc=%h rs=%h want 1 640 21 1234", k, valid_e_o, cv_e_o, pc_e_o, rs_data_e_o); end
    end
    flush_i = 1'b1;
    tick();
    vectors++; if (valid_e_o !== 1'b0 || cv_e_o !== 11'h000 || pc_e_o !== 8'h00) begin
      miscompares++; $display("FAIL stall_flush got v=%b cv=%h pc=%h want 0 000 00", valid_e_o, cv_e_o, pc_e_o); end
    idle();
  endtask

  task automatic test_halt();
    valid_d_i = 1'b1; instr_d_i = 16'hF000; pc_d_i = 8'h30;
    tick();
    vectors++; if (cv_e_o !== 11'h001 || halted_o !== 1'b0) begin
      miscompares++; $display("FAIL halt_ex got cv=%h h=%b want 001 0", cv_e_o, halted_o); end
    instr_d_i = 16'h1345; pc_d_i = 8'h31;
    tick();
    vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halt_set got %b want 1", halted_o); end
    #1;
    vectors++; if (stall_fd_o !== 1'b1) begin miscompares++; $display("FAIL halt_stall got %b want 1", stall_fd_o); end
    tick(); tick();
    vectors++; if (valid_e_o !== 1'b0 || cv_e_o !== 11'h000 || halted_o !== 1'b1) begin
      miscompares++; $display("FAIL halt_bubble got v=%b cv=%h h=%b want 0 000 1", valid_e_o, cv_e_o, halted_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (halted_o !== 1'b0 || valid_e_o !== 1'b0 || cv_e_o !== 11'h000 || pc_e_o !== 8'h00) begin
      miscompares++; $display("FAIL halt_rst got h=%b v=%b cv=%h pc=%h want 0 0 000 00", halted_o, valid_e_o, cv_e_o, pc_e_o); end
    valid_d_i = 1'b0; wb_en_i = 1'b1; wb_addr_i = 4'd0; wb_data_i = 16'hFFFF;
    tick();
    idle(); valid_d_i = 1'b1; instr_d_i = 16'h1000; pc_d_i = 8'h32;
    tick();
    vectors++; if (rs_data_e_o !== 16'h0000 || rt_data_e_o !== 16'h0000) begin
      miscompares++; $display("FAIL r0_zero got %h %h want 0000 0000", rs_data_e_o, rt_data_e_o); end
    idle();
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic exp_stall, exp_jump;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(99) < 4);
      valid_d_i = ($urandom_range(9) != 0);
      op = ($urandom_range(99) < 3) ? 4'hF : 4'($urandom_range(14));
      instr_d_i = {op, 2'b00, 2'($urandom_range(3)), 2'b00, 2'($urandom_range(3)), 4'($urandom_range(15))};
      pc_d_i = 8'($urandom);
      stall_i = ($urandom_range(9) == 0);
      flush_i = ($urandom_range(9) == 0);
      wb_en_i = ($urandom_range(1) == 1);
      wb_addr_i = 4'($urandom_range(3));
      wb_data_i = 16'($urandom);
      #1;
      exp_stall = m_hz() || stall_i || m_halted;
      exp_jump = valid_d_i && op == 4'h8 && !exp_stall && !flush_i;
      vectors++; if (stall_fd_o !== exp_stall || jump_o !== exp_jump || jump_addr_o !== instr_d_i[7:0]) begin
        miscompares++; $display("FAIL rnd_comb[%0d] got st=%b j=%b a=%h want %b %b %h", c, stall_fd_o, jump_o, jump_addr_o, exp_stall, exp_jump, instr_d_i[7:0]); end
      tick();
      vectors++; if (valid_e_o !== m_valid_e || cv_e_o !== m_cv_e || pc_e_o !== m_pc_e || halted_o !== m_halted) begin
        miscompares++; $display("FAIL rnd_ctrl[%0d] got v=%b cv=%h pc=%h h=%b want %b %h %h %b", c, valid_e_o, cv_e_o, pc_e_o, halted_o, m_valid_e, m_cv_e, m_pc_e, m_halted); end
      if (m_data_ok) begin
        vectors++; if ({rs_data_e_o, rt_data_e_o, imm8_e_o, rs_e_o, rt_e_o, rd_e_o} !== {m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd}) begin
          miscompares++; $display("FAIL rnd_data[%0d] got %h %h %h %h%h%h want %h %h %h %h%h%h", c, rs_data_e_o, rt_data_e_o, imm8_e_o, rs_e_o, rt_e_o, rd_e_o, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_rf_bypass();
    test_load_use();
    test_jump();
    test_stall_flush();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
